multi_gap_cmd_fsm: RTL and testbench

Parametrised successor to the team's 2-bit gap-terminated pattern FSM. It watches a per-cycle symbol stream `ain`. A non-idle symbol followed by `GAP` consecutive idle cycles commits a command (set, clear or toggle) to one of `CH` independent output bits in `yout`. The block sits between the switch/debounce front end and the LED/output register bank, and adds a commit strobe, an error strobe and an armed indicator.

---
 rtl/multi_gap_cmd_fsm.sv | 126 ++++++++++++
 tb/tb_multi_gap_cmd_fsm.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multi_gap_cmd_fsm.sv
// Gap-terminated command FSM: a non-idle symbol followed by GAP idle cycles
// commits a clear/toggle/set to one channel bit of yout.
module multi_gap_cmd_fsm #(
    parameter int CH   = 4,
    parameter int IDXW = (CH > 1) ? $clog2(CH) : 1,
    parameter int GAP  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IDXW+1:0] ain,
    output logic [CH-1:0]   yout,
    output logic            done,
    output logic            err,
    output logic            armed
);

    localparam int GW = $clog2(GAP + 1);
    localparam logic [GW-1:0] GCNT_LAST = GW'(GAP - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_CLR  = 2'b01,
        OP_TGL  = 2'b10,
        OP_SET  = 2'b11
    } op_t;

    state_t          state_q, state_d;
    op_t             op_q, op_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic [CH-1:0]   yout_q, yout_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    op_t             ain_op;
    logic [IDXW-1:0] ain_idx;
    logic            idx_valid;

    assign ain_op    = op_t'(ain[IDXW+1:IDXW]);
    assign ain_idx   = ain[IDXW-1:0];
    // The index field may be wider than needed when CH is not a power of two.
    assign idx_valid = (int'(idx_q) < CH);

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        gcnt_d  = gcnt_q;
        yout_d  = yout_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ain_op != OP_IDLE) begin
                    state_d = S_ARMED;
                    op_d    = ain_op;
                    idx_d   = ain_idx;
                    gcnt_d  = '0;
                end
            end
            S_ARMED: begin
                if (ain_op != OP_IDLE) begin
                    // Latest symbol wins and restarts the gap.
                    op_d   = ain_op;
                    idx_d  = ain_idx;
                    gcnt_d = '0;
                end else if (gcnt_q != GCNT_LAST) begin
                    gcnt_d = gcnt_q + GW'(1);
                end else begin
                    state_d = S_IDLE;
                    gcnt_d  = '0;
                    if (idx_valid) begin
                        done_d = 1'b1;
                        for (int i = 0; i < CH; i++) begin
                            if (idx_q == IDXW'(i)) begin
                                case (op_q)
                                    OP_CLR:  yout_d[i] = 1'b0;
                                    OP_TGL:  yout_d[i] = ~yout_q[i];
                                    OP_SET:  yout_d[i] = 1'b1;
                                    default: yout_d[i] = yout_q[i];
                                endcase
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_IDLE;
            idx_q   <= '0;
            gcnt_q  <= '0;
            yout_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            gcnt_q  <= gcnt_d;
            yout_q  <= yout_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign yout  = yout_q;
    assign done  = done_q;
    assign err   = err_q;
    assign armed = (state_q == S_ARMED);

endmodule

// File: tb/tb_multi_gap_cmd_fsm.sv
// Bench for multi_gap_cmd_fsm: directed scenarios plus random traffic, checked
// against a pending-command / idle-run-length model on a CH=4 and a CH=3 instance.
module tb_multi_gap_cmd_fsm;

    localparam int GAP = 2;

    logic       clk;
    logic       reset;
    logic [3:0] ain;

    logic [3:0] yout;
    logic       done, err, armed;
    logic [2:0] yout_e;
    logic       done_e, err_e, armed_e;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [3:0] y;
        logic       done;
        logic       err;
        logic       armed;
        logic [3:0] pend;
        int         run;
    } mdl_t;

    mdl_t m[2];

    multi_gap_cmd_fsm #(.CH(4), .IDXW(2), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .ain(ain),
        .yout(yout), .done(done), .err(err), .armed(armed)
    );

    multi_gap_cmd_fsm #(.CH(3), .IDXW(2), .GAP(GAP)) dut_e (
        .clk(clk), .reset(reset), .ain(ain),
        .yout(yout_e), .done(done_e), .err(err_e), .armed(armed_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // A command commits once GAP idle cycles have followed the last non-idle symbol.
    task automatic model_update(input int k, input int ch, input bit r, input logic [3:0] a);
        int idx;
        if (r) begin
            m[k].y = 4'b0; m[k].done = 1'b0; m[k].err = 1'b0;
            m[k].armed = 1'b0; m[k].pend = 4'b0; m[k].run = 0;
            return;
        end
        m[k].done = 1'b0;
        m[k].err  = 1'b0;
        if (a[3:2] != 2'b00) begin
            m[k].pend  = a;
            m[k].armed = 1'b1;
            m[k].run   = 0;
        end else if (m[k].armed) begin
            m[k].run++;
            if (m[k].run == GAP) begin
                m[k].armed = 1'b0;
                m[k].run   = 0;
                idx = int'(m[k].pend[1:0]);
                if (idx < ch) begin
                    m[k].done = 1'b1;
                    if (m[k].pend[3:2] == 2'b01)      m[k].y[idx] = 1'b0;
                    else if (m[k].pend[3:2] == 2'b10) m[k].y[idx] = ~m[k].y[idx];
                    else                              m[k].y[idx] = 1'b1;
                end else begin
                    m[k].err = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input string tag, input logic [3:0] a, input bit r);
        ain   = a;
        reset = r;
        @(posedge clk);
        #1;
        model_update(0, 4, r, a);
        model_update(1, 3, r, a);
        check({tag, ".yout"},    yout,                 m[0].y);
        check({tag, ".done"},    {3'b0, done},         {3'b0, m[0].done});
        check({tag, ".err"},     {3'b0, err},          {3'b0, m[0].err});
        check({tag, ".armed"},   {3'b0, armed},        {3'b0, m[0].armed});
        check({tag, ".e.yout"},  {1'b0, yout_e},       {1'b0, m[1].y[2:0]});
        check({tag, ".e.done"},  {3'b0, done_e},       {3'b0, m[1].done});
        check({tag, ".e.err"},   {3'b0, err_e},        {3'b0, m[1].err});
        check({tag, ".e.armed"}, {3'b0, armed_e},      {3'b0, m[1].armed});
        check({tag, ".excl"},    {2'b0, done, err} & {2'b0, done, done} & {2'b0, err, err}, 4'b0);
    endtask

    initial begin
        logic [3:0] sym;
        reset = 1'b1;
        ain   = 4'b0;

        // Reset then set ch2
        step("rst0", 4'h0, 1'b1);
        step("rst1", 4'h0, 1'b1);
        check("rst.yout", yout, 4'b0000);
        check("rst.armed", {3'b0, armed}, 4'b0);
        step("set2.sym", 4'b1110, 1'b0);
        check("set2.armed_a", {3'b0, armed}, 4'b0001);
        step("set2.i1", 4'h0, 1'b0);
        check("set2.armed_b", {3'b0, armed}, 4'b0001);
        step("set2.i2", 4'h0, 1'b0);
        check("set2.yout", yout, 4'b0100);
        check("set2.done", {3'b0, done}, 4'b0001);
        step("set2.i3", 4'h0, 1'b0);
        check("set2.done_off", {3'b0, done}, 4'b0000);

        // Toggle ch2 twice
        step("tg1.sym", 4'b1010, 1'b0);
        step("tg1.i1", 4'h0, 1'b0);
        step("tg1.i2", 4'h0, 1'b0);
        check("tg1.yout", yout, 4'b0000);
        step("tg2.sym", 4'b1010, 1'b0);
        step("tg2.i1", 4'h0, 1'b0);
        step("tg2.i2", 4'h0, 1'b0);
        check("tg2.yout", yout, 4'b0100);

        // Override: single idle between symbols never commits
        step("ov.set1", 4'b1101, 1'b0);
        step("ov.i1", 4'h0, 1'b0);
        check("ov.nocommit", {3'b0, done}, 4'b0);
        step("ov.tg0", 4'b1000, 1'b0);
        step("ov.i2", 4'h0, 1'b0);
        step("ov.i3", 4'h0, 1'b0);
        check("ov.yout", yout, 4'b0101);

        // Fill to 1111, then clear ch3 and hold
        for (int i = 0; i < 3; i++) step("fill.s1", (i == 0) ? 4'b1101 : 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) step("fill.s3", (i == 0) ? 4'b1111 : 4'h0, 1'b0);
        check("fill.yout", yout, 4'b1111);
        step("clr3.sym", 4'b0111, 1'b0);
        step("clr3.i1", 4'h0, 1'b0);
        step("clr3.i2", 4'h0, 1'b0);
        check("clr3.yout", yout, 4'b0111);
        for (int i = 0; i < 10; i++) step("hold", 4'h0, 1'b0);
        check("hold.yout", yout, 4'b0111);

        // Reset mid-ARMED
        step("rm.sym", 4'b1100, 1'b0);
        step("rm.i1", 4'h0, 1'b0);
        step("rm.rst", 4'h0, 1'b1);
        check("rm.yout", yout, 4'b0000);
        check("rm.armed", {3'b0, armed}, 4'b0);
        for (int i = 0; i < 4; i++) step("rm.idle", 4'h0, 1'b0);
        check("rm.nodone", {3'b0, done}, 4'b0);

        // Error path on the CH=3 instance
        step("er.sym", 4'b1111, 1'b0);
        step("er.i1", 4'h0, 1'b0);
        step("er.i2", 4'h0, 1'b0);
        check("er.err", {3'b0, err_e}, 4'b0001);
        check("er.done", {3'b0, done_e}, 4'b0000);
        check("er.yout", {1'b0, yout_e}, 4'b0000);
        step("er.i3", 4'h0, 1'b0);
        check("er.err_off", {3'b0, err_e}, 4'b0000);

        // Random traffic, idle-heavy so commits actually occur
        for (int i = 0; i < 400; i++) begin
            sym = 4'($urandom);
            if ($urandom_range(0, 99) < 55) sym[3:2] = 2'b00;
            step("rnd", sym, ($urandom_range(0, 99) < 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
